// File: rtl/sdrc_xfr_resp.sv
// Transfer-control responder for one SDRAM bank FSM: acks PRE/ACT/RD/WR, drives the
// registered SDRAM command pins, sequences data beats and inserts auto-refresh.
module sdrc_xfr_resp #(
    parameter int SDR_REQ_ID_W = 4,
    parameter int REQ_BW       = 12
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    b2x_req,
    input  logic [1:0]              b2x_cmd,
    input  logic [12:0]             b2x_addr,
    input  logic [REQ_BW-1:0]       b2x_len,
    input  logic [SDR_REQ_ID_W-1:0] b2x_id,
    input  logic                    b2x_start,
    input  logic                    b2x_last,
    output logic                    x2b_ack,
    output logic                    x2b_pre_ok,
    output logic                    x2b_act_ok,
    output logic                    x2b_rdok,
    output logic                    x2b_wrok,
    output logic                    xfr_ok,
    output logic                    x2b_refresh,
    input  logic                    rfsh_req,
    output logic                    rfsh_ack,
    input  logic [1:0]              cas_latency,
    input  logic [3:0]              trp_delay,
    input  logic [3:0]              trfc_delay,
    output logic                    sdr_cs_n,
    output logic                    sdr_ras_n,
    output logic                    sdr_cas_n,
    output logic                    sdr_we_n,
    output logic [12:0]             sdr_addr,
    output logic                    xfr_wr_next,
    output logic                    xfr_rd_valid,
    output logic                    xfr_last,
    output logic [SDR_REQ_ID_W-1:0] xfr_id,
    output logic                    xfr_start,
    output logic                    xfr_end,
    output logic [2:0]              fsm_state
);
    typedef enum logic [2:0] {IDLE, XFR, RF_DRAIN, RF_PRE, RF_TRP, RF_REF, RF_TRFC} state_t;

    localparam logic [1:0]  B2X_PRE = 2'b00, B2X_ACT = 2'b01, B2X_RD = 2'b10, B2X_WR = 2'b11;
    localparam logic [3:0]  CMD_DESEL = 4'b1111, CMD_NOOP = 4'b0111, CMD_ACT = 4'b0011,
                            CMD_RD = 4'b0101, CMD_WR = 4'b0100, CMD_BT = 4'b0110,
                            CMD_PRE = 4'b0010, CMD_REF = 4'b0001;
    localparam logic [12:0] COL_MASK = 13'h1BFF, PRE_ALL = 13'h0400;

    state_t                  state_q, state_n;
    logic [3:0]              cmd_q, cmd_n;
    logic [12:0]             addr_q, addr_n;
    logic [REQ_BW-1:0]       cnt_q, cnt_n, len_m1;
    logic                    is_wr_q, is_wr_n;
    logic [SDR_REQ_ID_W-1:0] id_q, id_n;
    logic                    start_q, start_n, end_q, end_n;
    logic                    wr_next_q, wr_next_n, wr_last_q, wr_last_n;
    logic                    refresh_q, refresh_n;
    logic [1:0]              wr_rec_q, wr_rec_n;
    logic [3:0]              timer_q, timer_n;
    logic [2:0]              rd_v_q, rd_v_n, rd_l_q, rd_l_n, rd_mask;
    logic [SDR_REQ_ID_W-1:0] rd_i_q [3];
    logic [SDR_REQ_ID_W-1:0] rd_i_n [3];
    logic [1:0]              cl_tap;
    logic                    rd_pend, rd_slot, rd_slot_last, tap_v, tap_l, idle_free;
    logic [SDR_REQ_ID_W-1:0] tap_i;

    // Read return pipeline: stage 0 takes the slot, beats emerge from stage cas_latency-1.
    always_comb begin
        cl_tap = (cas_latency == 2'd0) ? 2'd0 : cas_latency - 2'd1;
        case (cl_tap)
            2'd0:    begin rd_mask = 3'b001; tap_v = rd_v_q[0]; tap_l = rd_l_q[0]; tap_i = rd_i_q[0]; end
            2'd1:    begin rd_mask = 3'b011; tap_v = rd_v_q[1]; tap_l = rd_l_q[1]; tap_i = rd_i_q[1]; end
            default: begin rd_mask = 3'b111; tap_v = rd_v_q[2]; tap_l = rd_l_q[2]; tap_i = rd_i_q[2]; end
        endcase
        rd_pend = |(rd_v_q & rd_mask);
    end

    // Handshake: b2x_req holds its fields until x2b_ack; ack is combinational and the
    // request transfers on the rising edge where b2x_req && x2b_ack.
    assign idle_free  = (state_q == IDLE) && !rfsh_req;
    assign xfr_ok     = idle_free;
    assign x2b_rdok   = idle_free;
    assign x2b_wrok   = idle_free && !rd_pend;
    assign x2b_pre_ok = idle_free && (wr_rec_q == 2'd0);
    assign x2b_act_ok = x2b_pre_ok;

    always_comb begin
        case (b2x_cmd)
            B2X_PRE: x2b_ack = b2x_req && x2b_pre_ok;
            B2X_ACT: x2b_ack = b2x_req && x2b_act_ok;
            B2X_RD:  x2b_ack = b2x_req && x2b_rdok;
            default: x2b_ack = b2x_req && x2b_wrok;
        endcase
    end

    assign len_m1 = (b2x_len == '0) ? '0 : b2x_len - REQ_BW'(1);

    always_comb begin
        state_n      = state_q;
        cmd_n        = CMD_NOOP;
        addr_n       = addr_q;
        cnt_n        = cnt_q;
        is_wr_n      = is_wr_q;
        id_n         = id_q;
        start_n      = start_q;
        end_n        = end_q;
        wr_next_n    = 1'b0;
        wr_last_n    = 1'b0;
        refresh_n    = 1'b0;
        wr_rec_n     = (wr_rec_q != 2'd0) ? wr_rec_q - 2'd1 : 2'd0;
        timer_n      = timer_q;
        rd_slot      = 1'b0;
        rd_slot_last = 1'b0;
        case (state_q)
            IDLE: begin
                if (rfsh_req) begin
                    state_n = RF_DRAIN;
                end else if (x2b_ack) begin
                    case (b2x_cmd)
                        B2X_PRE: begin cmd_n = CMD_PRE; addr_n = b2x_addr & COL_MASK; end
                        B2X_ACT: begin cmd_n = CMD_ACT; addr_n = b2x_addr; end
                        default: begin
                            cmd_n     = (b2x_cmd == B2X_WR) ? CMD_WR : CMD_RD;
                            addr_n    = b2x_addr & COL_MASK;
                            cnt_n     = len_m1;
                            is_wr_n   = (b2x_cmd == B2X_WR);
                            id_n      = b2x_id;
                            start_n   = b2x_start;
                            end_n     = b2x_last;
                            wr_next_n = (b2x_cmd == B2X_WR);
                            wr_last_n = (b2x_cmd == B2X_WR) && (len_m1 == '0);
                            state_n   = XFR;
                        end
                    endcase
                end
            end
            XFR: begin
                rd_slot      = !is_wr_q;
                rd_slot_last = !is_wr_q && (cnt_q == '0);
                if (cnt_q == '0) begin
                    cmd_n   = CMD_BT;
                    state_n = IDLE;
                    if (is_wr_q) wr_rec_n = 2'd2;
                end else begin
                    cnt_n     = cnt_q - REQ_BW'(1);
                    wr_next_n = is_wr_q;
                    wr_last_n = is_wr_q && (cnt_q == REQ_BW'(1));
                end
            end
            RF_DRAIN: begin
                if (!rd_pend && wr_rec_q == 2'd0) begin
                    cmd_n   = CMD_PRE;
                    addr_n  = PRE_ALL;
                    state_n = RF_PRE;
                end
            end
            RF_PRE: begin
                timer_n = (trp_delay == 4'd0) ? 4'd0 : trp_delay - 4'd1;
                state_n = RF_TRP;
            end
            RF_TRP: begin
                if (timer_q == 4'd0) begin
                    cmd_n     = CMD_REF;
                    refresh_n = 1'b1;
                    state_n   = RF_REF;
                end else begin
                    timer_n = timer_q - 4'd1;
                end
            end
            RF_REF: begin
                timer_n = (trfc_delay == 4'd0) ? 4'd0 : trfc_delay - 4'd1;
                state_n = RF_TRFC;
            end
            RF_TRFC: begin
                if (timer_q == 4'd0) state_n = IDLE;
                else                 timer_n = timer_q - 4'd1;
            end
            default: state_n = IDLE;
        endcase
    end

    // Stages past the active tap stay empty so a shorter CAS latency drains at once.
    always_comb begin
        rd_v_n    = {rd_v_q[1] & (cl_tap == 2'd2), rd_v_q[0] & (cl_tap != 2'd0), rd_slot};
        rd_l_n    = {rd_l_q[1], rd_l_q[0], rd_slot_last};
        rd_i_n[0] = id_q;
        rd_i_n[1] = rd_i_q[0];
        rd_i_n[2] = rd_i_q[1];
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cmd_q     <= CMD_DESEL;
            addr_q    <= '0;
            cnt_q     <= '0;
            is_wr_q   <= 1'b0;
            id_q      <= '0;
            start_q   <= 1'b0;
            end_q     <= 1'b0;
            wr_next_q <= 1'b0;
            wr_last_q <= 1'b0;
            refresh_q <= 1'b0;
            wr_rec_q  <= 2'd0;
            timer_q   <= 4'd0;
            rd_v_q    <= 3'b000;
            rd_l_q    <= 3'b000;
            rd_i_q    <= '{default: '0};
        end else begin
            state_q   <= state_n;
            cmd_q     <= cmd_n;
            addr_q    <= addr_n;
            cnt_q     <= cnt_n;
            is_wr_q   <= is_wr_n;
            id_q      <= id_n;
            start_q   <= start_n;
            end_q     <= end_n;
            wr_next_q <= wr_next_n;
            wr_last_q <= wr_last_n;
            refresh_q <= refresh_n;
            wr_rec_q  <= wr_rec_n;
            timer_q   <= timer_n;
            rd_v_q    <= rd_v_n;
            rd_l_q    <= rd_l_n;
            rd_i_q    <= rd_i_n;
        end
    end

    assign {sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n} = cmd_q;
    assign sdr_addr     = addr_q;
    assign x2b_refresh  = refresh_q;
    assign rfsh_ack     = refresh_q;
    assign xfr_wr_next  = wr_next_q;
    assign xfr_rd_valid = tap_v;
    assign xfr_last     = wr_last_q | (tap_v & tap_l);
    assign xfr_id       = tap_v ? tap_i : id_q;
    assign xfr_start    = start_q;
    assign xfr_end      = end_q;
    assign fsm_state    = state_q;
endmodule

// File: tb/tb_sdrc_xfr_resp.sv
// Bench for sdrc_xfr_resp: per-feature tasks with inline timing checks plus a
// scoreboard of expected SDRAM commands and data beats.
module tb_sdrc_xfr_resp;
    localparam int IDW = 4;
    localparam int LW  = 12;
    localparam logic [3:0] C_DESEL = 4'b1111, C_NOOP = 4'b0111, C_ACT = 4'b0011, C_RD = 4'b0101,
                           C_WR = 4'b0100, C_BT = 4'b0110, C_PRE = 4'b0010, C_REF = 4'b0001;
    localparam logic [2:0] ST_IDLE = 3'd0, ST_XFR = 3'd1, ST_DRAIN = 3'd2;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic b2x_req = 1'b0;
    logic [1:0] b2x_cmd = 2'b00;
    logic [12:0] b2x_addr = '0;
    logic [LW-1:0] b2x_len = '0;
    logic [IDW-1:0] b2x_id = '0;
    logic b2x_start = 1'b0, b2x_last = 1'b0;
    logic rfsh_req = 1'b0;
    logic [1:0] cas_latency = 2'd3;
    logic [3:0] trp_delay = 4'd2, trfc_delay = 4'd6;
    logic x2b_ack, x2b_pre_ok, x2b_act_ok, x2b_rdok, x2b_wrok, xfr_ok, x2b_refresh, rfsh_ack;
    logic sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n;
    logic [12:0] sdr_addr;
    logic xfr_wr_next, xfr_rd_valid, xfr_last, xfr_start, xfr_end;
    logic [IDW-1:0] xfr_id;
    logic [2:0] fsm_state;

    int checks = 0;
    int errors = 0;
    logic [16:0] exp_q[$];
    logic [4:0]  wr_q[$];
    logic [4:0]  rd_q[$];

    wire [3:0] cmd_pins = {sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n};
    wire [4:0] flags = {x2b_pre_ok, x2b_act_ok, x2b_rdok, x2b_wrok, xfr_ok};

    always #5 clk = ~clk;

    sdrc_xfr_resp #(.SDR_REQ_ID_W(IDW), .REQ_BW(LW)) dut (
        .clk(clk), .reset_n(reset_n), .b2x_req(b2x_req), .b2x_cmd(b2x_cmd), .b2x_addr(b2x_addr),
        .b2x_len(b2x_len), .b2x_id(b2x_id), .b2x_start(b2x_start), .b2x_last(b2x_last),
        .x2b_ack(x2b_ack), .x2b_pre_ok(x2b_pre_ok), .x2b_act_ok(x2b_act_ok), .x2b_rdok(x2b_rdok),
        .x2b_wrok(x2b_wrok), .xfr_ok(xfr_ok), .x2b_refresh(x2b_refresh), .rfsh_req(rfsh_req),
        .rfsh_ack(rfsh_ack), .cas_latency(cas_latency), .trp_delay(trp_delay), .trfc_delay(trfc_delay),
        .sdr_cs_n(sdr_cs_n), .sdr_ras_n(sdr_ras_n), .sdr_cas_n(sdr_cas_n), .sdr_we_n(sdr_we_n),
        .sdr_addr(sdr_addr), .xfr_wr_next(xfr_wr_next), .xfr_rd_valid(xfr_rd_valid), .xfr_last(xfr_last),
        .xfr_id(xfr_id), .xfr_start(xfr_start), .xfr_end(xfr_end), .fsm_state(fsm_state)
    );

    // Scoreboard: every issued command and every data beat must match the next expected entry.
    always @(negedge clk) begin
        logic [16:0] ec;
        logic [4:0]  eb;
        if (reset_n) begin
            if (cmd_pins != C_NOOP && cmd_pins != C_DESEL) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL sb_cmd unexpected cmd %b addr %h", cmd_pins, sdr_addr);
                end else begin
                    ec = exp_q.pop_front();
                    if ({cmd_pins, sdr_addr} !== ec) begin
                        errors++; $display("FAIL sb_cmd got %b/%h exp %b/%h", cmd_pins, sdr_addr, ec[16:13], ec[12:0]);
                    end
                end
            end
            if (xfr_wr_next) begin
                checks++;
                if (wr_q.size() == 0) begin
                    errors++; $display("FAIL sb_wr unexpected beat id %h", xfr_id);
                end else begin
                    eb = wr_q.pop_front();
                    if ({xfr_last, xfr_id} !== eb) begin
                        errors++; $display("FAIL sb_wr got last/id %b/%h exp %b/%h", xfr_last, xfr_id, eb[4], eb[3:0]);
                    end
                end
            end
            if (xfr_rd_valid) begin
                checks++;
                if (rd_q.size() == 0) begin
                    errors++; $display("FAIL sb_rd unexpected beat id %h", xfr_id);
                end else begin
                    eb = rd_q.pop_front();
                    if ({xfr_last, xfr_id} !== eb) begin
                        errors++; $display("FAIL sb_rd got last/id %b/%h exp %b/%h", xfr_last, xfr_id, eb[4], eb[3:0]);
                    end
                end
            end
        end
    end

    task automatic next_cyc;
        @(posedge clk);
        #2;
    endtask

    task automatic idle_bus;
        b2x_req = 1'b0; b2x_cmd = 2'b00; b2x_addr = '0; b2x_len = '0;
        b2x_id = '0; b2x_start = 1'b0; b2x_last = 1'b0;
    endtask

    task automatic push_exp(input logic [1:0] cmd, input logic [12:0] addr,
                            input logic [LW-1:0] len, input logic [IDW-1:0] id);
        int n;
        case (cmd)
            2'b00: exp_q.push_back({C_PRE, addr & 13'h1BFF});
            2'b01: exp_q.push_back({C_ACT, addr});
            default: begin
                n = (len == '0) ? 1 : int'(len);
                exp_q.push_back({(cmd == 2'b11) ? C_WR : C_RD, addr & 13'h1BFF});
                for (int i = 0; i < n; i++) begin
                    if (cmd == 2'b11) wr_q.push_back({i == n - 1, id});
                    else              rd_q.push_back({i == n - 1, id});
                end
                exp_q.push_back({C_BT, addr & 13'h1BFF});
            end
        endcase
    endtask

    // Holds the request until acked (bounded), records expectations, returns in the next cycle.
    task automatic send_wait(input logic [1:0] cmd, input logic [12:0] addr, input logic [LW-1:0] len,
                             input logic [IDW-1:0] id, input logic st, input logic la,
                             output int waited, output logic [3:0] ack_cmd);
        b2x_req = 1'b1; b2x_cmd = cmd; b2x_addr = addr; b2x_len = len;
        b2x_id = id; b2x_start = st; b2x_last = la;
        waited = 0;
        #1;
        while (x2b_ack !== 1'b1 && waited < 60) begin
            next_cyc; #1; waited++;
        end
        ack_cmd = cmd_pins;
        if (x2b_ack === 1'b1) push_exp(cmd, addr, len, id);
        next_cyc;
        idle_bus;
    endtask

    task automatic test_reset;
        reset_n = 1'b0; idle_bus; rfsh_req = 1'b0;
        repeat (3) next_cyc;
        checks++; if (cmd_pins !== C_DESEL) begin errors++; $display("FAIL reset_cmd got %b exp %b", cmd_pins, C_DESEL); end
        checks++; if (sdr_addr !== 13'h0) begin errors++; $display("FAIL reset_addr got %h exp 0", sdr_addr); end
        checks++; if ({xfr_wr_next, xfr_rd_valid, xfr_last, x2b_refresh, rfsh_ack} !== 5'b0) begin
            errors++; $display("FAIL reset_outs got %b exp 00000", {xfr_wr_next, xfr_rd_valid, xfr_last, x2b_refresh, rfsh_ack});
        end
        checks++; if (xfr_id !== '0) begin errors++; $display("FAIL reset_id got %h exp 0", xfr_id); end
        checks++; if (fsm_state !== ST_IDLE) begin errors++; $display("FAIL reset_state got %0d exp 0", fsm_state); end
        reset_n = 1'b1;
        next_cyc;
        checks++; if (flags !== 5'b11111) begin errors++; $display("FAIL reset_flags got %b exp 11111", flags); end
        checks++; if (cmd_pins !== C_NOOP) begin errors++; $display("FAIL post_reset_cmd got %b exp %b", cmd_pins, C_NOOP); end
    endtask

    task automatic test_pre;
        int w; logic [3:0] ac;
        send_wait(2'b00, 13'h1FFF, '0, '0, 1'b0, 1'b0, w, ac);
        checks++; if (w !== 0) begin errors++; $display("FAIL pre_ack wait got %0d exp 0", w); end
        checks++; if ({cmd_pins, sdr_addr} !== {C_PRE, 13'h1BFF}) begin
            errors++; $display("FAIL pre_pins got %b/%h exp 0010/1bff", cmd_pins, sdr_addr);
        end
        checks++; if (flags !== 5'b11111) begin errors++; $display("FAIL pre_flags got %b exp 11111", flags); end
        next_cyc;
        checks++; if ({cmd_pins, sdr_addr} !== {C_NOOP, 13'h1BFF}) begin
            errors++; $display("FAIL pre_hold got %b/%h exp 0111/1bff", cmd_pins, sdr_addr);
        end
    endtask

    task automatic test_act_wr;
        int w; logic [3:0] ac;
        send_wait(2'b01, 13'd5, '0, '0, 1'b0, 1'b0, w, ac);
        checks++; if (w !== 0 || {cmd_pins, sdr_addr} !== {C_ACT, 13'd5}) begin
            errors++; $display("FAIL act got wait %0d pins %b/%h exp 0 0011/0005", w, cmd_pins, sdr_addr);
        end
        send_wait(2'b11, 13'd8, 12'd4, 4'd3, 1'b1, 1'b0, w, ac);
        checks++; if (w !== 0) begin errors++; $display("FAIL wr_ack wait got %0d exp 0", w); end
        for (int k = 0; k < 7; k++) begin
            checks++; if ({xfr_wr_next, xfr_last} !== {k <= 3, k == 3}) begin
                errors++; $display("FAIL wr_beat k%0d got %b%b exp %b%b", k, xfr_wr_next, xfr_last, k <= 3, k == 3);
            end
            checks++; if (x2b_pre_ok !== (k >= 6)) begin
                errors++; $display("FAIL wr_pre_ok k%0d got %b exp %b", k, x2b_pre_ok, k >= 6);
            end
            if (k == 0) begin
                checks++; if ({cmd_pins, sdr_addr, fsm_state, xfr_start, xfr_end} !== {C_WR, 13'd8, ST_XFR, 2'b10}) begin
                    errors++; $display("FAIL wr_cmd got %b/%h st %0d s/e %b%b", cmd_pins, sdr_addr, fsm_state, xfr_start, xfr_end);
                end
            end
            if (k == 4) begin
                checks++; if ({cmd_pins, fsm_state, x2b_rdok} !== {C_BT, ST_IDLE, 1'b1}) begin
                    errors++; $display("FAIL wr_bt got %b st %0d rdok %b exp 0110 0 1", cmd_pins, fsm_state, x2b_rdok);
                end
            end
            next_cyc;
        end
    endtask

    task automatic test_rd_cl3;
        int w; logic [3:0] ac;
        cas_latency = 2'd3;
        send_wait(2'b10, 13'h0420, 12'd3, 4'd9, 1'b0, 1'b1, w, ac);
        checks++; if (w !== 0) begin errors++; $display("FAIL rd_ack wait got %0d exp 0", w); end
        for (int k = 0; k < 7; k++) begin
            checks++; if ({xfr_rd_valid, xfr_last} !== {k >= 3 && k <= 5, k == 5}) begin
                errors++; $display("FAIL rd_beat k%0d got %b%b exp %b%b", k, xfr_rd_valid, xfr_last, k >= 3 && k <= 5, k == 5);
            end
            checks++; if (x2b_wrok !== (k >= 6)) begin
                errors++; $display("FAIL rd_wrok k%0d got %b exp %b", k, x2b_wrok, k >= 6);
            end
            if (k == 0) begin
                checks++; if ({cmd_pins, sdr_addr} !== {C_RD, 13'h0020}) begin
                    errors++; $display("FAIL rd_cmd got %b/%h exp 0101/0020", cmd_pins, sdr_addr);
                end
            end
            if (k == 3) begin
                checks++; if (cmd_pins !== C_BT) begin errors++; $display("FAIL rd_bt got %b exp 0110", cmd_pins); end
            end
            next_cyc;
        end
    endtask

    task automatic test_refresh;
        int pre_c, ref_c, idle_c, pulses, pair_bad;
        trp_delay = 4'd2; trfc_delay = 4'd6;
        rfsh_req = 1'b1;
        b2x_req = 1'b1; b2x_cmd = 2'b10; b2x_addr = 13'h10; b2x_len = 12'd1;
        #1;
        checks++; if (x2b_ack !== 1'b0) begin errors++; $display("FAIL rf_ack got %b exp 0", x2b_ack); end
        checks++; if (flags !== 5'b00000) begin errors++; $display("FAIL rf_flags got %b exp 00000", flags); end
        next_cyc;
        idle_bus;
        checks++; if (fsm_state !== ST_DRAIN) begin errors++; $display("FAIL rf_drain got %0d exp 2", fsm_state); end
        exp_q.push_back({C_PRE, 13'h0400});
        exp_q.push_back({C_REF, 13'h0400});
        pre_c = -1; ref_c = -1; idle_c = -1; pulses = 0; pair_bad = 0;
        for (int t = 1; t < 40 && idle_c < 0; t++) begin
            if (cmd_pins == C_PRE) pre_c = t;
            if (cmd_pins == C_REF) ref_c = t;
            if (x2b_refresh !== rfsh_ack) pair_bad++;
            if (x2b_refresh === 1'b1) begin pulses++; rfsh_req = 1'b0; end
            if (ref_c >= 0 && fsm_state == ST_IDLE) idle_c = t;
            next_cyc;
        end
        checks++; if (pre_c !== 2) begin errors++; $display("FAIL rf_pre_cycle got %0d exp 2", pre_c); end
        checks++; if (ref_c - pre_c !== 3) begin errors++; $display("FAIL rf_trp got %0d exp 3", ref_c - pre_c); end
        checks++; if (pulses !== 1 || pair_bad !== 0) begin
            errors++; $display("FAIL rf_pulse got pulses %0d unpaired %0d exp 1 0", pulses, pair_bad);
        end
        checks++; if (idle_c - ref_c !== 7) begin errors++; $display("FAIL rf_trfc got %0d exp 7", idle_c - ref_c); end
        checks++; if (flags !== 5'b11111) begin errors++; $display("FAIL rf_after_flags got %b exp 11111", flags); end
    endtask

    task automatic test_rd_len0;
        int w; logic [3:0] ac;
        cas_latency = 2'd1;
        send_wait(2'b10, 13'h1C05, 12'd0, 4'd6, 1'b1, 1'b1, w, ac);
        checks++; if (w !== 0 || {cmd_pins, sdr_addr, xfr_rd_valid} !== {C_RD, 13'h1805, 1'b0}) begin
            errors++; $display("FAIL len0_cmd got wait %0d %b/%h v%b exp 0 0101/1805 v0", w, cmd_pins, sdr_addr, xfr_rd_valid);
        end
        next_cyc;
        checks++; if ({cmd_pins, xfr_rd_valid, xfr_last, xfr_id} !== {C_BT, 2'b11, 4'd6}) begin
            errors++; $display("FAIL len0_beat got %b v%b l%b id%h exp 0110 v1 l1 id6", cmd_pins, xfr_rd_valid, xfr_last, xfr_id);
        end
        next_cyc;
        checks++; if ({xfr_rd_valid, x2b_wrok} !== 2'b01) begin
            errors++; $display("FAIL len0_after got v%b wrok%b exp v0 wrok1", xfr_rd_valid, x2b_wrok);
        end
    endtask

    task automatic test_back_to_back;
        int w; logic [3:0] ac;
        cas_latency = 2'd2;
        send_wait(2'b10, 13'h30, 12'd2, 4'd4, 1'b0, 1'b0, w, ac);
        send_wait(2'b10, 13'h31, 12'd2, 4'd5, 1'b0, 1'b1, w, ac);
        checks++; if (w !== 2 || ac !== C_BT) begin
            errors++; $display("FAIL b2b_ack got wait %0d cmd %b exp 2 0110", w, ac);
        end
        for (int n = 0; n < 12; n++) begin
            send_wait(2'($urandom_range(0, 3)), 13'($urandom_range(0, 8191)), LW'($urandom_range(0, 5)),
                      IDW'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), w, ac);
            checks++; if (w >= 60) begin errors++; $display("FAIL b2b_rand_timeout req %0d got no ack", n); end
        end
        repeat (20) next_cyc;
        checks++; if (exp_q.size() + wr_q.size() + rd_q.size() !== 0) begin
            errors++; $display("FAIL sb_drain got %0d/%0d/%0d pending exp 0/0/0", exp_q.size(), wr_q.size(), rd_q.size());
        end
    endtask

    task automatic test_reset_mid_wr;
        int w; logic [3:0] ac;
        send_wait(2'b11, 13'h44, 12'd8, 4'd2, 1'b1, 1'b1, w, ac);
        next_cyc;
        next_cyc;
        reset_n = 1'b0;
        next_cyc;
        checks++; if ({cmd_pins, xfr_wr_next, xfr_last, fsm_state} !== {C_DESEL, 2'b00, ST_IDLE}) begin
            errors++; $display("FAIL mid_reset got %b wn%b l%b st%0d exp 1111 wn0 l0 st0", cmd_pins, xfr_wr_next, xfr_last, fsm_state);
        end
        exp_q.delete(); wr_q.delete(); rd_q.delete();
        reset_n = 1'b1;
        repeat (12) next_cyc;
        checks++; if ({fsm_state, xfr_wr_next} !== {ST_IDLE, 1'b0}) begin
            errors++; $display("FAIL mid_reset_after got st%0d wn%b exp st0 wn0", fsm_state, xfr_wr_next);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog simulation time exceeded");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_pre;
        test_act_wr;
        test_rd_cl3;
        test_refresh;
        test_rd_len0;
        test_back_to_back;
        test_reset_mid_wr;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
